// File: rtl/axi_mon_pkg.sv
// axi_mon_pkg
// Shared definitions for the AXI4-Lite protocol monitor:
//   - error index enumeration (bit positions inside err_flags)
//   - error vector / error code widths
//   - AXI response encodings
//   - lowest_err(): priority encoder picking the lowest set error index
package axi_mon_pkg;

    localparam int ERR_W      = 8;
    localparam int ERR_CODE_W = 3;

    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_AR_TO      = 3'd0,
        ERR_AW_TO      = 3'd1,
        ERR_W_TO       = 3'd2,
        ERR_R_TO       = 3'd3,
        ERR_B_TO       = 3'd4,
        ERR_STABILITY  = 3'd5,
        ERR_UNEXP_RESP = 3'd6,
        ERR_OVERFLOW   = 3'd7
    } err_idx_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Walk from the top down so the lowest set index is the one that sticks.
    function automatic logic [ERR_CODE_W-1:0] lowest_err(input logic [ERR_W-1:0] v);
        logic [ERR_CODE_W-1:0] code;
        code = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) code = i[ERR_CODE_W-1:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/axi_mon_timeout.sv
// axi_mon_timeout
// Counts consecutive cycles in which a stall condition holds and trips once
// per stall when the condition has been true for TIMEOUT cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   cond     : stall condition for the current cycle
//   trip     : combinational, high in the TIMEOUT-th consecutive stall cycle
module axi_mon_timeout #(
    parameter int TIMEOUT = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic cond,
    output logic trip
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    // Parking one step past LAST keeps trip from re-firing during a long stall.
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!cond) begin
            cnt <= '0;
        end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign trip = cond && (cnt == LAST);

endmodule

// File: rtl/axi_lite_protocol_monitor.sv
// axi_lite_protocol_monitor
// Passive AXI4-Lite link monitor. Detects channel timeouts, handshake
// stability violations, unexpected responses and outstanding overflow.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ar*/r*/aw*/w*/b*         : observed AXI4-Lite channel signals (inputs only)
//   err_clr                  : clears the sticky error flags
//   err_flags                : sticky error bits, indexed by err_idx_e
//   err_valid                : one-cycle strobe for every cycle with a new error
//   err_code                 : lowest error index of the latest strobe
//   rd_outstanding           : reads accepted but not yet answered
//   wr_outstanding           : max(accepted AW, accepted W) not yet answered
//
// Handshake semantics: a transfer happens on a rising edge where the
// channel's valid and ready are both high. Once valid is raised without
// ready, valid must stay high and the payload must stay constant until the
// transfer happens; anything else is a STABILITY error.
module axi_lite_protocol_monitor
    import axi_mon_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int TIMEOUT         = 128,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    input  logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    input  logic                  bready,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err_flags,
    output logic                  err_valid,
    output logic [ERR_CODE_W-1:0] err_code,
    output logic [CNT_W-1:0]      rd_outstanding,
    output logic [CNT_W-1:0]      wr_outstanding
);

    localparam logic [CNT_W:0] LIM = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0] SAT = (CNT_W + 1)'(MAX_OUTSTANDING + 1);

    // Count after one cycle, one bit wider so overflow is visible.
    // A decrement on an empty counter is dropped (saturate at 0).
    function automatic logic [CNT_W:0] cnt_sum(input logic [CNT_W-1:0] c,
                                               input logic inc, input logic dec_req);
        logic dec;
        dec = dec_req && (c != '0);
        return {1'b0, c} + (CNT_W + 1)'(inc) - (CNT_W + 1)'(dec);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_clamp(input logic [CNT_W:0] s);
        return (s > SAT) ? SAT[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid  && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bvalid  && bready;

    logic [CNT_W-1:0] rd_cnt, aw_cnt, w_cnt;

    // Previous-cycle history for the stability check.
    logic                hist_q;
    logic                ar_stall_q, r_stall_q, aw_stall_q, w_stall_q, b_stall_q;
    logic [ADDR_W-1:0]   araddr_q, awaddr_q;
    logic [DATA_W-1:0]   rdata_q, wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [1:0]          rresp_q, bresp_q;

    logic [4:0] to_trip;

    axi_mon_timeout #(.TIMEOUT(TIMEOUT)) u_to_ar (
        .clk(clk), .rst(rst), .cond(arvalid && !arready), .trip(to_trip[0]));
    axi_mon_timeout #(.TIMEOUT(TIMEOUT)) u_to_aw (
        .clk(clk), .rst(rst), .cond(awvalid && !awready), .trip(to_trip[1]));
    axi_mon_timeout #(.TIMEOUT(TIMEOUT)) u_to_w (
        .clk(clk), .rst(rst), .cond(wvalid && !wready), .trip(to_trip[2]));
    // Response timeouts only run while something is actually owed.
    axi_mon_timeout #(.TIMEOUT(TIMEOUT)) u_to_r (
        .clk(clk), .rst(rst), .cond((rd_cnt != '0) && !rvalid), .trip(to_trip[3]));
    axi_mon_timeout #(.TIMEOUT(TIMEOUT)) u_to_b (
        .clk(clk), .rst(rst), .cond((aw_cnt != '0) && (w_cnt != '0) && !bvalid),
        .trip(to_trip[4]));

    logic [CNT_W:0]   rd_sum, aw_sum, w_sum;
    logic             unstable;
    logic [ERR_W-1:0] det;

    always_comb begin
        rd_sum = cnt_sum(rd_cnt, ar_hs, r_hs);
        aw_sum = cnt_sum(aw_cnt, aw_hs, b_hs);
        w_sum  = cnt_sum(w_cnt, w_hs, b_hs);

        unstable = (ar_stall_q && (!arvalid || (araddr != araddr_q)))
                || (r_stall_q  && (!rvalid  || (rdata  != rdata_q) || (rresp != rresp_q)))
                || (aw_stall_q && (!awvalid || (awaddr != awaddr_q)))
                || (w_stall_q  && (!wvalid  || (wdata  != wdata_q) || (wstrb != wstrb_q)))
                || (b_stall_q  && (!bvalid  || (bresp  != bresp_q)));

        det                 = '0;
        det[ERR_AR_TO]      = to_trip[0];
        det[ERR_AW_TO]      = to_trip[1];
        det[ERR_W_TO]       = to_trip[2];
        det[ERR_R_TO]       = to_trip[3];
        det[ERR_B_TO]       = to_trip[4];
        det[ERR_STABILITY]  = hist_q && unstable;
        det[ERR_UNEXP_RESP] = (r_hs && (rd_cnt == '0))
                           || (b_hs && ((aw_cnt == '0) || (w_cnt == '0)));
        det[ERR_OVERFLOW]   = (ar_hs && (rd_sum > LIM))
                           || (aw_hs && (aw_sum > LIM))
                           || (w_hs  && (w_sum  > LIM));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt     <= '0;
            aw_cnt     <= '0;
            w_cnt      <= '0;
            hist_q     <= 1'b0;
            ar_stall_q <= 1'b0;
            r_stall_q  <= 1'b0;
            aw_stall_q <= 1'b0;
            w_stall_q  <= 1'b0;
            b_stall_q  <= 1'b0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rresp_q    <= '0;
            bresp_q    <= '0;
            err_flags  <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
        end else begin
            rd_cnt     <= cnt_clamp(rd_sum);
            aw_cnt     <= cnt_clamp(aw_sum);
            w_cnt      <= cnt_clamp(w_sum);
            hist_q     <= 1'b1;
            ar_stall_q <= arvalid && !arready;
            r_stall_q  <= rvalid  && !rready;
            aw_stall_q <= awvalid && !awready;
            w_stall_q  <= wvalid  && !wready;
            b_stall_q  <= bvalid  && !bready;
            araddr_q   <= araddr;
            awaddr_q   <= awaddr;
            rdata_q    <= rdata;
            wdata_q    <= wdata;
            wstrb_q    <= wstrb;
            rresp_q    <= rresp;
            bresp_q    <= bresp;
            // A clear never wipes an error detected in the same cycle.
            err_flags  <= (err_clr ? '0 : err_flags) | det;
            err_valid  <= |det;
            if (|det) err_code <= lowest_err(det);
        end
    end

    assign rd_outstanding = rd_cnt;
    assign wr_outstanding = (aw_cnt > w_cnt) ? aw_cnt : w_cnt;

endmodule

// File: tb/tb_axi_lite_protocol_monitor.sv
module tb_axi_lite_protocol_monitor;
    import axi_mon_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 128;
    localparam int MAX_OUT = 4;
    localparam int OW      = $clog2(MAX_OUT + 1) + 1;
    localparam int SB_W    = 12 + 2 * OW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0]   araddr, awaddr;
    logic                arvalid, arready, rvalid, rready;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]   rdata, wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [1:0]          rresp, bresp;
    logic                err_clr;
    logic [7:0]          err_flags;
    logic                err_valid;
    logic [2:0]          err_code;
    logic [OW-1:0]       rd_outstanding, wr_outstanding;

    axi_lite_protocol_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .err_clr(err_clr), .err_flags(err_flags), .err_valid(err_valid),
        .err_code(err_code), .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on whole-number counts and stall lengths: an error fires when a
    // stall has lasted exactly TIMEOUT cycles; counts are clipped to
    // [0, MAX_OUT+1].
    int   m_rd, m_aw, m_w;
    int   m_run[5];
    bit   m_hist;
    bit   p_ar, p_r, p_aw, p_w, p_b;
    logic [ADDR_W-1:0]   p_araddr, p_awaddr;
    logic [DATA_W-1:0]   p_rdata, p_wdata;
    logic [DATA_W/8-1:0] p_wstrb;
    logic [1:0]          p_rresp, p_bresp;
    logic [7:0] m_flags;
    logic       m_valid;
    logic [2:0] m_code;

    task automatic model_reset();
        m_rd = 0; m_aw = 0; m_w = 0; m_hist = 0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
        m_flags = '0; m_valid = 0; m_code = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] det;
        bit cond[5];
        int t;
        bit found;
        det = '0;
        cond[0] = arvalid && !arready;
        cond[1] = awvalid && !awready;
        cond[2] = wvalid && !wready;
        cond[3] = (m_rd > 0) && !rvalid;
        cond[4] = (m_aw > 0) && (m_w > 0) && !bvalid;
        for (int i = 0; i < 5; i++) begin
            m_run[i] = cond[i] ? m_run[i] + 1 : 0;
            if (m_run[i] == TIMEOUT) det[i] = 1'b1;
        end
        if (m_hist) begin
            if ((p_ar && (!arvalid || araddr != p_araddr)) ||
                (p_r  && (!rvalid || rdata != p_rdata || rresp != p_rresp)) ||
                (p_aw && (!awvalid || awaddr != p_awaddr)) ||
                (p_w  && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) ||
                (p_b  && (!bvalid || bresp != p_bresp)))
                det[ERR_STABILITY] = 1'b1;
        end
        if ((rvalid && rready && m_rd == 0) ||
            (bvalid && bready && (m_aw == 0 || m_w == 0)))
            det[ERR_UNEXP_RESP] = 1'b1;
        // read count
        t = m_rd - ((rvalid && rready) ? 1 : 0);
        if (t < 0) t = 0;
        if (arvalid && arready) begin
            t = t + 1;
            if (t > MAX_OUT) det[ERR_OVERFLOW] = 1'b1;
        end
        m_rd = (t > MAX_OUT + 1) ? MAX_OUT + 1 : t;
        // write address count
        t = m_aw - ((bvalid && bready) ? 1 : 0);
        if (t < 0) t = 0;
        if (awvalid && awready) begin
            t = t + 1;
            if (t > MAX_OUT) det[ERR_OVERFLOW] = 1'b1;
        end
        m_aw = (t > MAX_OUT + 1) ? MAX_OUT + 1 : t;
        // write data count
        t = m_w - ((bvalid && bready) ? 1 : 0);
        if (t < 0) t = 0;
        if (wvalid && wready) begin
            t = t + 1;
            if (t > MAX_OUT) det[ERR_OVERFLOW] = 1'b1;
        end
        m_w = (t > MAX_OUT + 1) ? MAX_OUT + 1 : t;
        // outputs
        m_flags = (err_clr ? 8'h00 : m_flags) | det;
        m_valid = (det != 0);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (det[i] && !found) begin
                m_code = i[2:0];
                found = 1;
            end
        end
        // history for next cycle
        m_hist = 1;
        p_ar = arvalid && !arready; p_r = rvalid && !rready;
        p_aw = awvalid && !awready; p_w = wvalid && !wready; p_b = bvalid && !bready;
        p_araddr = araddr; p_awaddr = awaddr; p_rdata = rdata; p_rresp = rresp;
        p_wdata = wdata; p_wstrb = wstrb; p_bresp = bresp;
        exp_q.push_back({m_flags, m_valid, m_code, OW'(m_rd),
                         OW'((m_aw > m_w) ? m_aw : m_w)});
    endtask

    task automatic compare_outputs();
        logic [SB_W-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("err_flags", 32'(err_flags), 32'(e[SB_W-1 -: 8]));
        check("err_valid", 32'(err_valid), 32'(e[SB_W-9]));
        check("err_code",  32'(err_code),  32'(e[SB_W-10 -: 3]));
        check("rd_out",    32'(rd_outstanding), 32'(e[2*OW-1 -: OW]));
        check("wr_out",    32'(wr_outstanding), 32'(e[OW-1:0]));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the model and the DUT both sample
    // them at the rising edge, outputs are checked 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
        if (err_valid) pulse_cnt++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        araddr = '0; arvalid = 0; arready = 0;
        rdata = '0; rresp = RESP_OKAY; rvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; awready = 0;
        wdata = '0; wstrb = '0; wvalid = 0; wready = 0;
        bresp = RESP_OKAY; bvalid = 0; bready = 0;
        err_clr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 32'(err_flags), 32'd0);
        check({tag, "_valid"}, 32'(err_valid), 32'd0);
        check({tag, "_code"},  32'(err_code),  32'd0);
        check({tag, "_rd"},    32'(rd_outstanding), 32'd0);
        check({tag, "_wr"},    32'(wr_outstanding), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        #1;
        check_all_zero("reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic gen_ch(input logic v, input logic r,
                          output logic nv, output logic nr, output logic chg);
        if (v && !r) begin
            nv  = ($urandom_range(0, 15) != 0);
            chg = ($urandom_range(0, 15) == 0);
        end else begin
            nv  = ($urandom_range(0, 1) == 1);
            chg = ($urandom_range(0, 1) == 1);
        end
        nr = ($urandom_range(0, 2) != 0);
    endtask

    task automatic rand_cycle();
        logic c;
        gen_ch(arvalid, arready, arvalid, arready, c);
        if (c) araddr = ADDR_W'($urandom_range(0, 7) * 4);
        gen_ch(rvalid, rready, rvalid, rready, c);
        if (c) begin
            rdata = $urandom();
            rresp = ($urandom_range(0, 1) == 1) ? RESP_OKAY : RESP_SLVERR;
        end
        gen_ch(awvalid, awready, awvalid, awready, c);
        if (c) awaddr = ADDR_W'($urandom_range(0, 7) * 4);
        gen_ch(wvalid, wready, wvalid, wready, c);
        if (c) begin
            wdata = $urandom();
            wstrb = (DATA_W/8)'($urandom_range(0, 15));
        end
        gen_ch(bvalid, bready, bvalid, bready, c);
        if (c) bresp = ($urandom_range(0, 1) == 1) ? RESP_EXOKAY : RESP_DECERR;
        err_clr = ($urandom_range(0, 15) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Legal read with 3-cycle arready delay, then write with W before AW.
        arvalid = 1; araddr = 32'h1000;
        repeat (3) tick();
        arready = 1; tick();
        arvalid = 0; arready = 0;
        rvalid = 1; rready = 1; rdata = 32'h1234_5678; rresp = RESP_OKAY; tick();
        rvalid = 0; rready = 0;
        wvalid = 1; wready = 1; wdata = 32'hDEAD_BEEF; wstrb = '1; tick();
        wvalid = 0; wready = 0;
        awvalid = 1; awready = 1; awaddr = 32'h2000; tick();
        awvalid = 0; awready = 0;
        bvalid = 1; bready = 1; bresp = RESP_OKAY; tick();
        bvalid = 0; bready = 0;
        tick();
        check("legal_flags", 32'(err_flags), 32'h00);
        check("legal_rd", 32'(rd_outstanding), 32'd0);
        check("legal_wr", 32'(wr_outstanding), 32'd0);

        // AR stall for TIMEOUT cycles and beyond.
        do_reset();
        arvalid = 1; araddr = 32'h40; pulse_cnt = 0;
        repeat (TIMEOUT) tick();
        check("ar_to_strobe", 32'(err_valid), 32'd1);
        repeat (20) tick();
        check("ar_to_pulses", 32'(pulse_cnt), 32'd1);
        check("ar_to_code", 32'(err_code), 32'd0);
        check("ar_to_flags", 32'(err_flags), 32'h01);

        // AW address change during a stall, then clear.
        do_reset();
        awvalid = 1; awaddr = 32'h10; tick();
        awaddr = 32'h14; tick();
        check("stab_code", 32'(err_code), 32'd5);
        check("stab_bit", 32'(err_flags[ERR_STABILITY]), 32'd1);
        awready = 1; err_clr = 1; tick();
        awvalid = 0; awready = 0; err_clr = 0;
        check("stab_clr", 32'(err_flags), 32'h00);

        // R handshake with no prior AR.
        do_reset();
        rvalid = 1; rready = 1; tick();
        rvalid = 0; rready = 0;
        check("unexp_code", 32'(err_code), 32'd6);
        check("unexp_rd", 32'(rd_outstanding), 32'd0);

        // Five reads with no response, then R timeout.
        do_reset();
        arvalid = 1; arready = 1;
        for (int i = 0; i < 5; i++) begin
            araddr = ADDR_W'(32'h100 + i * 4);
            tick();
        end
        arvalid = 0; arready = 0;
        check("ovf_code", 32'(err_code), 32'd7);
        check("ovf_rd", 32'(rd_outstanding), 32'd5);
        repeat (TIMEOUT + 10) tick();
        check("rto_flags", 32'(err_flags), 32'h88);

        // Unexpected B in the same cycle as an AW timeout, then async reset.
        do_reset();
        awvalid = 1; awaddr = 32'h80;
        repeat (TIMEOUT - 1) tick();
        bvalid = 1; bready = 1; tick();
        bvalid = 0; bready = 0;
        check("same_cycle_code", 32'(err_code), 32'd1);
        check("same_cycle_flags", 32'(err_flags), 32'h42);
        awready = 1; tick();
        awvalid = 0; awready = 0;
        arvalid = 1; arready = 1;
        repeat (3) tick();
        #2 rst = 1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;

        // Randomized traffic in two segments separated by a reset.
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 1500; i++) begin
                rand_cycle();
                tick();
            end
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
